// File: rtl/audio_i2s_tx.sv
// I2S clock-master transmitter: divides Clock_50 into BCLK/LRCK, latches one
// L/R sample pair per 64-bit frame and announces each frame start on data_over.
module audio_i2s_tx #(
  parameter int BCLK_HALF        = 16,
  parameter int DATA_OVER_CYCLES = 256
) (
  input  logic        Clock_50,
  input  logic        reset_h,
  input  logic        INIT_FINISH,
  input  logic [15:0] LDATA,
  input  logic [15:0] RDATA,
  output logic        data_over,
  output logic        AUD_BCLK,
  output logic        AUD_DACLRCK,
  output logic        AUD_DACDAT
);

  localparam int DIV_W   = $clog2(BCLK_HALF);
  localparam int PULSE_W = $clog2(DATA_OVER_CYCLES + 1);
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(BCLK_HALF - 1);
  localparam logic [PULSE_W-1:0] PULSE_MAX = PULSE_W'(DATA_OVER_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [DIV_W-1:0]   div_r, div_s;
  logic [5:0]         bit_r, bit_s;
  logic [PULSE_W-1:0] pulse_r, pulse_s;
  logic [31:0]        hold_r, hold_s;
  logic               bclk_r, bclk_s;
  logic               dov_r, dov_s;
  logic               lrck_r, lrck_s;
  logic               dat_r, dat_s;
  logic               frame_start_s;

  // Slot 0 is the I2S one-bit delay, slots 1..16 carry the word MSB first.
  function automatic logic serial_bit(input logic [5:0] bc, input logic [31:0] hold);
    logic [15:0] word;
    logic [4:0]  p;
    logic [3:0]  idx;
    word = bc[5] ? hold[15:0] : hold[31:16];
    p    = bc[4:0];
    idx  = 4'(5'd16 - p);
    if ((p >= 5'd1) && (p <= 5'd16)) begin
      serial_bit = word[idx];
    end else begin
      serial_bit = 1'b0;
    end
  endfunction

  // Next-state and next-output computation for the whole transmitter.
  always_comb begin
    state_s       = state_r;
    div_s         = div_r;
    bclk_s        = bclk_r;
    bit_s         = bit_r;
    pulse_s       = pulse_r;
    hold_s        = hold_r;
    dov_s         = dov_r;
    lrck_s        = lrck_r;
    dat_s         = dat_r;
    frame_start_s = 1'b0;

    case (state_r)
      IDLE: begin
        div_s  = {DIV_W{1'b0}};
        bclk_s = 1'b0;
        bit_s  = 6'd0;
        if (INIT_FINISH) begin
          state_s       = RUN;
          frame_start_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (INIT_FINISH) begin
          state_s = RUN;
          if (div_r == DIV_LAST) begin
            div_s  = {DIV_W{1'b0}};
            bclk_s = ~bclk_r;
            if (bclk_r) begin
              bit_s         = bit_r + 6'd1;
              frame_start_s = (bit_r == 6'd63);
            end else begin
              bit_s = bit_r;
            end
          end else begin
            div_s = div_r + DIV_W'(1);
          end
        end else begin
          state_s = IDLE;
          div_s   = {DIV_W{1'b0}};
          bclk_s  = 1'b0;
          bit_s   = 6'd0;
        end
      end
      default: begin
        state_s = IDLE;
        div_s   = {DIV_W{1'b0}};
        bclk_s  = 1'b0;
        bit_s   = 6'd0;
      end
    endcase

    // The pulse counter saturates at the pulse length until the next frame start.
    if (frame_start_s) begin
      hold_s  = {LDATA, RDATA};
      pulse_s = {PULSE_W{1'b0}};
    end else if ((state_s == RUN) && (pulse_r < PULSE_MAX)) begin
      pulse_s = pulse_r + PULSE_W'(1);
    end else if (state_s == RUN) begin
      pulse_s = pulse_r;
    end else begin
      pulse_s = {PULSE_W{1'b0}};
    end

    if (state_s == RUN) begin
      dov_s  = (pulse_s < PULSE_MAX);
      lrck_s = bit_s[5];
      dat_s  = serial_bit(bit_s, hold_s);
    end else begin
      dov_s  = 1'b0;
      lrck_s = 1'b0;
      dat_s  = 1'b0;
    end
  end

  // State, counter, hold and output registers.
  always_ff @(posedge Clock_50 or posedge reset_h) begin
    if (reset_h) begin
      state_r <= IDLE;
      div_r   <= {DIV_W{1'b0}};
      bclk_r  <= 1'b0;
      bit_r   <= 6'd0;
      pulse_r <= {PULSE_W{1'b0}};
      hold_r  <= 32'd0;
      dov_r   <= 1'b0;
      lrck_r  <= 1'b0;
      dat_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      div_r   <= div_s;
      bclk_r  <= bclk_s;
      bit_r   <= bit_s;
      pulse_r <= pulse_s;
      hold_r  <= hold_s;
      dov_r   <= dov_s;
      lrck_r  <= lrck_s;
      dat_r   <= dat_s;
    end
  end

  assign data_over   = dov_r;
  assign AUD_BCLK    = bclk_r;
  assign AUD_DACLRCK = lrck_r;
  assign AUD_DACDAT  = dat_r;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: default and minimum-parameter instances compared
// every cycle against a frame-position model derived from the timing rules.
module tb_audio_i2s_tx;

  logic        clk = 1'b0;
  logic        reset_h;
  logic        init;
  logic [15:0] ldata, rdata;
  logic        dov0, bclk0, lrck0, dat0;
  logic        dov1, bclk1, lrck1, dat1;

  int compared   = 0;
  int mismatched = 0;

  int          hp[2] = '{16, 2};
  int          dp[2] = '{256, 1};
  bit          run_m[2];
  int          k_m[2];
  logic [31:0] hold_m[2];

  always #5 clk = ~clk;

  audio_i2s_tx dut0 (
    .Clock_50(clk), .reset_h(reset_h), .INIT_FINISH(init),
    .LDATA(ldata), .RDATA(rdata),
    .data_over(dov0), .AUD_BCLK(bclk0), .AUD_DACLRCK(lrck0), .AUD_DACDAT(dat0)
  );

  audio_i2s_tx #(.BCLK_HALF(2), .DATA_OVER_CYCLES(1)) dut1 (
    .Clock_50(clk), .reset_h(reset_h), .INIT_FINISH(init),
    .LDATA(ldata), .RDATA(rdata),
    .data_over(dov1), .AUD_BCLK(bclk1), .AUD_DACLRCK(lrck1), .AUD_DACDAT(dat1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: position k (cycles) within the current frame plus the sample latched at its start.
  function automatic void model_edge(int i);
    if (reset_h || !init) begin
      run_m[i] = 1'b0;
    end else if (!run_m[i]) begin
      run_m[i]  = 1'b1;
      k_m[i]    = 0;
      hold_m[i] = {ldata, rdata};
    end else begin
      k_m[i]++;
      if (k_m[i] == 128 * hp[i]) begin
        k_m[i]    = 0;
        hold_m[i] = {ldata, rdata};
      end
    end
  endfunction

  // Expected {data_over, BCLK, LRCK, DAT}.
  function automatic logic [3:0] exp_out(int i);
    int h, k, b, p;
    logic [15:0] w;
    logic d;
    if (!run_m[i]) return 4'b0000;
    h = hp[i];
    k = k_m[i];
    b = k / (2 * h);
    p = b % 32;
    w = (b >= 32) ? hold_m[i][15:0] : hold_m[i][31:16];
    d = (p >= 1 && p <= 16) ? w[16 - p] : 1'b0;
    return {k < dp[i], (k % (2 * h)) >= h, b >= 32, d};
  endfunction

  task automatic check_outputs();
    logic [3:0] got, exp;
    for (int i = 0; i < 2; i++) begin
      got = (i == 0) ? {dov0, bclk0, lrck0, dat0} : {dov1, bclk1, lrck1, dat1};
      exp = exp_out(i);
      check($sformatf("i%0d_data_over", i), {31'd0, got[3]}, {31'd0, exp[3]});
      check($sformatf("i%0d_bclk", i),      {31'd0, got[2]}, {31'd0, exp[2]});
      check($sformatf("i%0d_lrck", i),      {31'd0, got[1]}, {31'd0, exp[1]});
      check($sformatf("i%0d_dacdat", i),    {31'd0, got[0]}, {31'd0, exp[0]});
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_outputs();
  endtask

  initial begin
    int pub;
    int n;
    reset_h = 1'b1;
    init    = 1'b0;
    ldata   = 16'h0000;
    rdata   = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      run_m[i]  = 1'b0;
      k_m[i]    = 0;
      hold_m[i] = 32'd0;
    end
    repeat (3) step();
    reset_h = 1'b0;

    // Held idle with random samples: everything must stay quiet.
    for (int c = 0; c < 5000; c++) begin
      ldata = 16'($urandom);
      rdata = 16'($urandom);
      step();
    end

    // Random samples changing every cycle across several frames.
    init = 1'b1;
    for (int c = 0; c < 4 * 2048 + 7; c++) begin
      step();
      ldata = 16'($urandom);
      rdata = 16'($urandom);
    end

    // Fixed pattern across two full frames.
    ldata = 16'hA5C3;
    rdata = 16'h8001;
    repeat (2 * 2048 + 3) step();

    // Handoff: publish 1, 2, 3... one cycle after each default-instance frame start.
    pub = 1;
    for (int c = 0; c < 4 * 2048; c++) begin
      step();
      if (run_m[0] && k_m[0] == 0) begin
        ldata = 16'(pub);
        rdata = ~16'(pub);
        pub++;
      end
    end

    // Drop INIT_FINISH at bit_cnt 40 of the default instance, then re-raise.
    for (int c = 0; c < 3000; c++) begin
      step();
      if (run_m[0] && k_m[0] == 40 * 2 * hp[0]) break;
    end
    check("reached_bit40", {31'd0, run_m[0]}, 32'd1);
    init = 1'b0;
    repeat (50) step();
    init  = 1'b1;
    ldata = 16'($urandom);
    rdata = 16'($urandom);
    repeat (2048 + 100) step();

    // Asynchronous reset at a random point inside a frame.
    n = $urandom_range(100, 2000);
    for (int c = 0; c < n; c++) begin
      step();
      ldata = 16'($urandom);
      rdata = 16'($urandom);
    end
    #2;
    reset_h = 1'b1;
    #1;
    check("async_rst_i0", {28'd0, dov0, bclk0, lrck0, dat0}, 32'd0);
    check("async_rst_i1", {28'd0, dov1, bclk1, lrck1, dat1}, 32'd0);
    run_m[0] = 1'b0;
    run_m[1] = 1'b0;
    repeat (3) step();
    reset_h = 1'b0;
    ldata   = 16'h5A3C;
    rdata   = 16'hC001;
    repeat (2048 + 50) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Serial audio transmitter sitting directly downstream of the flash sample fetcher. It drives the codec DAC bit/word clocks as clock master. It latches one 16-bit left/right sample pair per frame and shifts it out in I2S format. Each frame start is announced on `data_over`, the strobe the fetcher uses to publish its next sample and begin its next flash read.

## Interface
Parameters:
- `BCLK_HALF`, 16: Clock_50 cycles per BCLK half-period; must be ≥ 2.
- `DATA_OVER_CYCLES`, 256: length in Clock_50 cycles of the `data_over` high pulse; must be ≥ 1 and < 128*`BCLK_HALF`.

Ports:
- `Clock_50`  in  1  system clock, the only clock; all logic is on its rising edge.
- `reset_h`  in  1  asynchronous, active-high reset.
- `INIT_FINISH`  in  1  high once codec register configuration is complete; low holds the block idle.
- `LDATA`  in  16  left sample, two's complement, published by the fetcher.
- `RDATA`  in  16  right sample, two's complement.
- `data_over`  out  1  frame-start strobe, high for `DATA_OVER_CYCLES` cycles.
- `AUD_BCLK`  out  1  codec bit clock.
- `AUD_DACLRCK`  out  1  codec word clock; 0 = left, 1 = right.
- `AUD_DACDAT`  out  1  serial DAC data.

## Operation
- States:
  - IDLE: all outputs 0, counters held at 0.
  - RUN: clocks and data active.
- Reset (async, any time): state IDLE. `AUD_BCLK`=0, `AUD_DACLRCK`=0, `AUD_DACDAT`=0, `data_over`=0. Hold register=0, `div_cnt`=0, `bit_cnt`=0, `pulse_cnt`=0.
- IDLE → RUN: on the first edge where `INIT_FINISH`=1, treated as a frame start (see below).
- RUN → IDLE: on any edge where `INIT_FINISH`=0, including mid-frame. All outputs and counters return to reset values on that edge, and the hold register is kept.
- `div_cnt` runs 0..`BCLK_HALF`-1 and wraps. At wrap, `AUD_BCLK` toggles.
  - 0→1 is the BCLK rising edge; 1→0 is the falling edge.
- `bit_cnt` is 6 bits, 0..63. It increments (wrapping 63→0) on each BCLK falling edge. One frame = 64 BCLK = 128*`BCLK_HALF` Clock_50 cycles; default 2048 cycles ≈ 24.41 kHz.
- Frame start happens on IDLE→RUN, or on the falling edge where `bit_cnt` wraps 63→0. On that edge:
  - hold register ← {`LDATA`, `RDATA`}
  - `data_over` ← 1
  - `pulse_cnt` ← 0
- Because the hold register captures on the same edge that raises `data_over`, it receives the sample the fetcher published on the previous `data_over` rising edge.
- `data_over` stays high while `pulse_cnt` < `DATA_OVER_CYCLES`, then falls and stays low until the next frame start.
- `AUD_DACLRCK` = `bit_cnt[5]`; it changes only on BCLK falling edges.
- `AUD_DACDAT` is updated on BCLK falling edges (and at frame start). Let p = `bit_cnt[4:0]` and S = left hold when `bit_cnt[5]`=0, right hold otherwise:
  - p = 0: 0 (the I2S one-bit delay).
  - p = 1..16: S[16-p], MSB first.
  - p = 17..31: 0.
- The codec samples on the BCLK rising edge, so data is stable `BCLK_HALF` cycles either side.
- `LDATA`/`RDATA` changes outside a frame start have no effect on the frame in flight.

## Timing
- Frame start (t=0): `data_over`, `AUD_BCLK`=0, `AUD_DACLRCK`=0 and `AUD_DACDAT`=0 all registered on this edge.
- `AUD_BCLK` rises at t=`BCLK_HALF` and falls at t=2*`BCLK_HALF`.
- Left MSB is driven from t=2*`BCLK_HALF`; left LSB from t=32*`BCLK_HALF`.
- `AUD_DACLRCK` rises at t=64*`BCLK_HALF`, and right MSB is driven from t=66*`BCLK_HALF`.
- `data_over` falls at t=`DATA_OVER_CYCLES`.
- The next frame start is at t=128*`BCLK_HALF`.
- All outputs are registered; no combinational path from any input to any output.
- `INIT_FINISH` rising: the first frame start is on the first edge where the input is seen high, so latency is 1 edge.

## Test plan
- Reset mid-frame: assert `reset_h` asynchronously at an arbitrary point in RUN -> all four outputs 0 immediately, without waiting for a clock edge. After release with `INIT_FINISH`=1, the first frame start is on the next edge.
- `INIT_FINISH`=0 for 5000 cycles -> all outputs 0 throughout. Raise it -> `data_over` high 1 edge later, high for exactly 256 cycles, period 2048 cycles.
- Sample shifting: `LDATA`=16'hA5C3, `RDATA`=16'h8001 held -> bits on the BCLK rising edges are:
  - 0, then 1010010111000011, then 15 zeros while `AUD_DACLRCK`=0;
  - 0, then 1000000000000001, then 15 zeros while `AUD_DACLRCK`=1.
- Sample handoff: the model updates `LDATA` one cycle after each `data_over` rise, with values 1, 2, 3… -> frame n transmits the value published at the previous rise. The hold register never changes mid-frame.
- `INIT_FINISH` dropped at `bit_cnt`=40 -> outputs 0 on the next edge. Re-raised -> a full fresh frame starting at `bit_cnt`=0 with `data_over` pulse.
- Parameter sweep `BCLK_HALF`=2, `DATA_OVER_CYCLES`=1 -> BCLK period 4 cycles, frame 256 cycles, `data_over` a single-cycle pulse every frame. Data ordering is the same as above.
